if_fetch_stage: RTL and testbench
=================================

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0000, bubble instruction written to the IF/ID register.
REQ-003 SHALL have one clock and asynchronous active-low reset: clk_i  input  1  rising-edge clock; rst_n_i  input  1  asynchronous reset, active low.
REQ-004 SHALL have port start_i  input  1  run enable; PC advances only while high.
REQ-005 SHALL have port stall_i  input  1  hazard stall; holds PC and IF/ID.
REQ-006 SHALL have port branch_taken_i  input  1  taken branch resolved in ID.
REQ-007 SHALL have port branch_target_i  input  32  branch target address.
REQ-008 SHALL have port jump_i  input  1  jump decoded in ID.
REQ-009 SHALL have port jump_target_i  input  32  jump target address.
REQ-010 SHALL have port imem_addr_o  output  32  instruction memory address, equal to current PC.
REQ-011 SHALL have port imem_instr_i  input  32  instruction word, combinational read of imem_addr_o.
REQ-012 SHALL have port if_id_instr_o  output  32  registered instruction to decode.
REQ-013 SHALL have port if_id_pc4_o  output  32  registered PC+4 of that instruction.
REQ-014 SHALL have port if_id_valid_o  output  1  high when if_id_instr_o holds a real fetched instruction.

Function
REQ-015 SHALL implement a two-state FSM: IDLE (PC held, bubbles issued) and RUN (fetching).
REQ-016 SHALL move IDLE->RUN on a rising clock edge with start_i=1, and RUN->IDLE on an edge with start_i=0.
REQ-017 SHALL update PC and IF/ID only on edges where state is RUN; the edge that leaves IDLE writes a bubble, and fetching starts one cycle later.
REQ-018 SHALL, in IDLE, hold PC and load IF/ID with NOP_INSTR, pc4 unchanged, valid=0.
REQ-019 SHALL select next-PC in RUN by priority: stall_i > jump_i > branch_taken_i > PC+4.
REQ-020 SHALL, on stall_i=1, hold PC, if_id_instr_o, if_id_pc4_o and if_id_valid_o unchanged, ignoring jump_i and branch_taken_i that cycle.
REQ-021 SHALL, on jump_i=1 (no stall), load PC with jump_target_i and flush IF/ID to NOP_INSTR, valid=0, pc4 unchanged.
REQ-022 SHALL, on branch_taken_i=1 with jump_i=0 (no stall), load PC with branch_target_i and flush IF/ID identically.
REQ-023 SHALL treat jump_i and branch_taken_i both high as jump; the branch is dropped.
REQ-024 SHALL, otherwise in RUN, load PC with PC+4 and load IF/ID with imem_instr_i, PC+4, valid=1.
REQ-025 SHALL compute PC+4 modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000), with no overflow flag.
REQ-026 SHALL force bits [1:0] of every loaded PC to 2'b00; target bits [1:0] are ignored.
REQ-027 SHALL drive imem_addr_o combinationally from the PC register, with zero-cycle memory latency: the instruction at PC appears in IF/ID one edge later.

Reset
REQ-028 SHALL, on rst_n_i=0 and regardless of clock, set PC=RESET_PC (bits [1:0] forced 0), state=IDLE, if_id_instr_o=NOP_INSTR, if_id_pc4_o=0 and if_id_valid_o=0.
REQ-029 SHALL abandon any in-flight fetch, stall or redirect when reset asserts mid-operation; no pending redirect survives reset.
REQ-030 SHALL treat reset release as synchronous to clk_i, with the first state evaluation on the first edge after rst_n_i rises.

Verification
REQ-031 Reset then start_i=1, imem returns addr+100 -> imem_addr_o sequence 0,0,4,8; IF/ID valid from the third edge with instr=100, pc4=4.
REQ-032 In RUN at PC=8, stall_i=1 for 2 cycles with branch_taken_i=1 -> PC stays 8 and IF/ID is unchanged; after release, sequential fetch resumes at 8.
REQ-033 In RUN at PC=8, jump_i=1, jump_target_i=32'h40, branch_taken_i=1, branch_target_i=32'h80 -> next PC=32'h40, IF/ID valid=0, instr=NOP_INSTR.
REQ-034 PC=32'hFFFF_FFFC, no redirect -> next PC=0 and if_id_pc4_o=0; branch_target_i=32'h13 -> PC=32'h10.
REQ-035 start_i dropped in RUN at PC=20 -> PC holds 20 and bubbles issue; start_i re-raised -> fetch resumes at 20.
REQ-036 rst_n_i pulsed low between clock edges during a stall at PC=32'h40 -> outputs immediately reset, PC=0 and state=IDLE.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID pipeline register.
// Single-cycle fetch with a combinational imem read; a stall freezes the PC and IF/ID, and a redirect flushes IF/ID.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc4_o,
    output logic        if_id_valid_o
);

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        ACT_HOLD     = 2'd0,
        ACT_BUBBLE   = 2'd1,
        ACT_REDIRECT = 2'd2,
        ACT_FETCH    = 2'd3
    } act_t;

    state_t      state_q, state_d;
    act_t        act;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i)  state_d = ST_RUN;
            ST_RUN:  if (!start_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (datapath action) ----------------
    // Priority in RUN: stall, then jump, then branch, then sequential fetch.
    always_comb begin
        act = ACT_BUBBLE;
        case (state_q)
            ST_IDLE: act = ACT_BUBBLE;
            ST_RUN: begin
                if (stall_i) begin
                    act = ACT_HOLD;
                end else if (jump_i || branch_taken_i) begin
                    act = ACT_REDIRECT;
                end else begin
                    act = ACT_FETCH;
                end
            end
            default: act = ACT_BUBBLE;
        endcase
    end

    // ---------------- Datapath ----------------
    assign pc_plus4        = pc_q + 32'd4;
    assign redirect_target = jump_i ? jump_target_i : branch_target_i;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        case (act)
            ACT_HOLD: begin
                pc_d    = pc_q;
            end
            ACT_BUBBLE: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
            ACT_REDIRECT: begin
                // pc4 is left as-is on a flush; only valid marks the slot empty.
                pc_d    = redirect_target & ALIGN_MASK;
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
            ACT_FETCH: begin
                pc_d    = pc_plus4 & ALIGN_MASK;
                instr_d = imem_instr_i;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
            end
            default: begin
                pc_d    = pc_q;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q    <= RESET_PC_ALIGNED;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr_o   = pc_q;
    assign if_id_instr_o = instr_q;
    assign if_id_pc4_o   = pc4_q;
    assign if_id_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized traffic against a behavioural fetch model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [31:0] off;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          m_run;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;

    logic [96:0] obs;
    assign obs = {imem_addr, ifid_instr, ifid_pc4, ifid_valid};

    // Instruction memory: word at address A reads as A + off
    assign imem_instr = imem_addr + off;

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .start_i         (start),
        .stall_i         (stall),
        .branch_taken_i  (br),
        .branch_target_i (bt),
        .jump_i          (jmp),
        .jump_target_i   (jt),
        .imem_addr_o     (imem_addr),
        .imem_instr_i    (imem_instr),
        .if_id_instr_o   (ifid_instr),
        .if_id_pc4_o     (ifid_pc4),
        .if_id_valid_o   (ifid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_run = 0; m_pc = 32'd0; m_instr = NOP; m_pc4 = 32'd0; m_valid = 1'b0;
    endtask

    // What one clock edge does, stated from the stage's rules
    task automatic model_edge();
        if (!m_run) begin
            m_instr = NOP; m_valid = 1'b0;
        end else if (stall) begin
            // everything frozen
        end else if (jmp) begin
            m_pc = {jt[31:2], 2'b00}; m_instr = NOP; m_valid = 1'b0;
        end else if (br) begin
            m_pc = {bt[31:2], 2'b00}; m_instr = NOP; m_valid = 1'b0;
        end else begin
            m_instr = m_pc + off;
            m_pc4   = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b1;
        end
        m_run = start;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (imem_addr !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h want=%h", imem_addr, 32'd0); end
        checks++; if (ifid_instr !== NOP) begin failures++; $display("FAIL reset_instr got=%h want=%h", ifid_instr, NOP); end
        checks++; if (ifid_pc4 !== 32'd0) begin failures++; $display("FAIL reset_pc4 got=%h want=%h", ifid_pc4, 32'd0); end
        checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", ifid_valid); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (imem_addr !== 32'd0) begin failures++; $display("FAIL idle_hold_pc got=%h want=0", imem_addr); end
    endtask

    task automatic test_start_seq();
        logic [31:0] want_addr [3];
        want_addr[0] = 32'd0; want_addr[1] = 32'd4; want_addr[2] = 32'd8;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== {m_pc, m_instr, m_pc4, m_valid}) begin
                failures++; $display("FAIL start_seq[%0d] got=%h want=%h", i, obs, {m_pc, m_instr, m_pc4, m_valid});
            end
            checks++;
            if (imem_addr !== want_addr[i]) begin
                failures++; $display("FAIL start_addr[%0d] got=%h want=%h", i, imem_addr, want_addr[i]);
            end
            if (i == 1) begin
                checks++;
                if ({ifid_valid, ifid_instr, ifid_pc4} !== {1'b1, 32'd100, 32'd4}) begin
                    failures++; $display("FAIL first_fetch got=%b/%h/%h want=1/64/4", ifid_valid, ifid_instr, ifid_pc4);
                end
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1; br = 1'b1; bt = 32'h80;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({imem_addr, ifid_instr, ifid_pc4, ifid_valid} !== {32'd8, 32'd104, 32'd8, 1'b1}) begin
                failures++; $display("FAIL stall_hold[%0d] got=%h want=%h", i, obs, {32'd8, 32'd104, 32'd8, 1'b1});
            end
        end
        stall = 1'b0; br = 1'b0;
        step();
        checks++;
        if (obs !== {m_pc, m_instr, m_pc4, m_valid} || imem_addr !== 32'd12 || ifid_instr !== 32'd108) begin
            failures++; $display("FAIL stall_resume got=%h want=%h", obs, {m_pc, m_instr, m_pc4, m_valid});
        end
    endtask

    task automatic test_jump_priority();
        br = 1'b1; bt = 32'd8;
        step();
        checks++;
        if (obs !== {m_pc, m_instr, m_pc4, m_valid}) begin
            failures++; $display("FAIL branch_to_8 got=%h want=%h", obs, {m_pc, m_instr, m_pc4, m_valid});
        end
        jmp = 1'b1; jt = 32'h40; br = 1'b1; bt = 32'h80;
        step();
        checks++;
        if ({imem_addr, ifid_instr, ifid_valid} !== {32'h40, NOP, 1'b0}) begin
            failures++; $display("FAIL jump_over_branch got=%h/%h/%b want=40/%h/0", imem_addr, ifid_instr, ifid_valid, NOP);
        end
        checks++;
        if (obs !== {m_pc, m_instr, m_pc4, m_valid}) begin
            failures++; $display("FAIL jump_model got=%h want=%h", obs, {m_pc, m_instr, m_pc4, m_valid});
        end
        jmp = 1'b0; br = 1'b0;
    endtask

    task automatic test_wrap();
        jmp = 1'b1; jt = 32'hFFFF_FFFF;
        step();
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL jump_align got=%h want=fffffffc", imem_addr);
        end
        jmp = 1'b0;
        step();
        checks++;
        if ({imem_addr, ifid_pc4, ifid_valid, ifid_instr} !== {32'd0, 32'd0, 1'b1, 32'h0000_0060}) begin
            failures++; $display("FAIL pc_wrap got=%h/%h/%b/%h want=0/0/1/60", imem_addr, ifid_pc4, ifid_valid, ifid_instr);
        end
        br = 1'b1; bt = 32'h13;
        step();
        checks++;
        if (imem_addr !== 32'h10 || obs !== {m_pc, m_instr, m_pc4, m_valid}) begin
            failures++; $display("FAIL branch_align got=%h want=%h", obs, {m_pc, m_instr, m_pc4, m_valid});
        end
        br = 1'b0;
    endtask

    task automatic test_start_drop();
        // The edge that samples start low still fetches (PC 16 -> 20)
        start = 1'b0;
        step();
        checks++;
        if (imem_addr !== 32'd20) begin failures++; $display("FAIL drop_edge got=%h want=14", imem_addr); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({imem_addr, ifid_instr, ifid_valid} !== {32'd20, NOP, 1'b0}) begin
                failures++; $display("FAIL idle_bubble[%0d] got=%h/%h/%b want=14/%h/0", i, imem_addr, ifid_instr, ifid_valid, NOP);
            end
        end
        start = 1'b1;
        step();
        checks++;
        if ({imem_addr, ifid_valid} !== {32'd20, 1'b0}) begin
            failures++; $display("FAIL restart_bubble got=%h/%b want=14/0", imem_addr, ifid_valid);
        end
        step();
        checks++;
        if ({imem_addr, ifid_instr, ifid_pc4, ifid_valid} !== {32'd24, 32'd120, 32'd24, 1'b1}) begin
            failures++; $display("FAIL restart_fetch got=%h want=%h", obs, {32'd24, 32'd120, 32'd24, 1'b1});
        end
    endtask

    task automatic test_reset_mid();
        jmp = 1'b1; jt = 32'h40;
        step();
        jmp = 1'b0; stall = 1'b1; br = 1'b1; bt = 32'h100;
        step();
        checks++;
        if (imem_addr !== 32'h40) begin failures++; $display("FAIL pre_reset_pc got=%h want=40", imem_addr); end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== {32'd0, NOP, 32'd0, 1'b0}) begin
            failures++; $display("FAIL async_reset got=%h want=%h", obs, {32'd0, NOP, 32'd0, 1'b0});
        end
        stall = 1'b0; br = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        checks++;
        if ({imem_addr, ifid_valid} !== {32'd0, 1'b0}) begin
            failures++; $display("FAIL post_reset_idle got=%h/%b want=0/0", imem_addr, ifid_valid);
        end
        step();
        checks++;
        if (obs !== {m_pc, m_instr, m_pc4, m_valid} || imem_addr !== 32'd4) begin
            failures++; $display("FAIL post_reset_run got=%h want=%h", obs, {m_pc, m_instr, m_pc4, m_valid});
        end
    endtask

    task automatic test_random();
        off = $urandom;
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 9) != 0);
            stall = ($urandom_range(0, 4) == 0);
            jmp   = ($urandom_range(0, 7) == 0);
            br    = ($urandom_range(0, 5) == 0);
            jt    = $urandom;
            bt    = $urandom;
            step();
            checks++;
            if (obs !== {m_pc, m_instr, m_pc4, m_valid}) begin
                failures++; $display("FAIL random[%0d] got=%h want=%h", i, obs, {m_pc, m_instr, m_pc4, m_valid});
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; br = 1'b0; jmp = 1'b0;
        bt = 32'd0; jt = 32'd0; off = 32'd100;
        model_reset();
        test_reset();
        test_start_seq();
        test_stall();
        test_jump_priority();
        test_wrap();
        test_start_drop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
